// File: rtl/decoder_pkg.sv
// Shared mode/state encodings for the decoder_scan block.
// The same 2-bit encoding is used for the mode input and the FSM state.
package decoder_pkg;

  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_DECODE = 2'b01;
  localparam logic [1:0] ST_SCAN   = 2'b10;
  localparam logic [1:0] ST_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    MODE_OFF    = ST_OFF,
    MODE_DECODE = ST_DECODE,
    MODE_SCAN   = ST_SCAN,
    MODE_HOLD   = ST_HOLD
  } mode_t;

  typedef mode_t state_t;

endpackage

// File: rtl/tick_gen.sv
// Scan prescaler: counts 0..DIV-1 while run is high and flags the terminal count.
// clr wins over run; with run low the count is frozen.
module tick_gen
  import decoder_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = run && (count_r == TERM);

  // Prescaler counter: clear, wrap on terminal count, advance when running, else hold.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= {CW{1'b0}};
    end else if (tick) begin
      count_r <= {CW{1'b0}};
    end else if (run) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot decoder with a prescaled scanning mode; all outputs registered.
// The state register simply follows the mode input one cycle late.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    a,
  input  logic [1:0]      mode,
  input  logic            en,
  output logic [2**N-1:0] y,
  output logic [N-1:0]    idx,
  output logic            wrap,
  output logic            valid
);

  localparam int W = 2**N;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t         state_r;
  mode_t          mode_s;
  logic           scan_entry_s;
  logic           clr_s;
  logic           run_s;
  logic           tick_s;
  logic [N-1:0]   idx_inc_s;
  logic [N-1:0]   idx_next_s;
  logic           wrap_next_s;
  logic           valid_next_s;
  logic [W-1:0]   y_next_s;

  assign mode_s    = mode_t'(mode);
  assign idx_inc_s = idx + N'(1);

  // HOLD counts as "already scanning" so HOLD->SCAN resumes instead of restarting.
  assign scan_entry_s = (state_r != MODE_SCAN) && (state_r != MODE_HOLD);
  assign clr_s = (mode_s == MODE_OFF) || (mode_s == MODE_DECODE) ||
                 ((mode_s == MODE_SCAN) && scan_entry_s);
  assign run_s = en && (mode_s == MODE_SCAN) && !scan_entry_s;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .run   (run_s),
    .tick  (tick_s)
  );

  // Next index / wrap / output selection for the mode being entered.
  always_comb begin
    idx_next_s  = idx;
    wrap_next_s = 1'b0;
    case (mode_s)
      MODE_OFF:    idx_next_s = idx;
      MODE_DECODE: idx_next_s = a;
      MODE_SCAN: begin
        if (scan_entry_s) begin
          idx_next_s = {N{1'b0}};
        end else if (tick_s) begin
          idx_next_s  = idx_inc_s;
          wrap_next_s = (idx_inc_s == {N{1'b0}});
        end else begin
          idx_next_s = idx;
        end
      end
      MODE_HOLD:   idx_next_s = idx;
      default:     idx_next_s = idx;
    endcase
    valid_next_s = (mode_s != MODE_OFF) && en;
    // A single shift; an unknown select propagates to an all-X output.
    if (valid_next_s) begin
      y_next_s = ONE << idx_next_s;
    end else begin
      y_next_s = {W{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MODE_OFF;
      y       <= {W{1'b0}};
      idx     <= {N{1'b0}};
      wrap    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_r <= mode_s;
      y       <= y_next_s;
      idx     <= idx_next_s;
      wrap    <= wrap_next_s;
      valid   <= valid_next_s;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: vector table plus multi-cycle scan sequences,
// with a second N=1/DIV=1 instance for the fastest scan.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] a;
  logic [1:0] mode;
  logic       en;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;
  logic       valid;

  logic       reset1;
  logic [0:0] a1;
  logic [1:0] mode1;
  logic       en1;
  logic [1:0] y1;
  logic [0:0] idx1;
  logic       wrap1;
  logic       valid1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_scan #(.N(3), .DIV(4)) dut (
    .clk(clk), .reset(reset), .a(a), .mode(mode), .en(en),
    .y(y), .idx(idx), .wrap(wrap), .valid(valid)
  );

  decoder_scan #(.N(1), .DIV(1)) dut1 (
    .clk(clk), .reset(reset1), .a(a1), .mode(mode1), .en(en1),
    .y(y1), .idx(idx1), .wrap(wrap1), .valid(valid1)
  );

  typedef struct {
    logic       rst;
    logic [1:0] md;
    logic       e;
    logic [2:0] sel;
    logic [7:0] ey;
    logic [2:0] eidx;
    logic       ewrap;
    logic       evalid;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic r, input logic [1:0] m, input logic e, input logic [2:0] s);
    reset = r;
    mode  = m;
    en    = e;
    a     = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pack(input logic [7:0] py, input logic [2:0] pi,
                                       input logic pw, input logic pv);
    return {3'b000, py, pi, pw, pv};
  endfunction

  function automatic logic [15:0] cur();
    return pack(y, idx, wrap, valid);
  endfunction

  initial begin
    logic [2:0] ei;
    reset = 1'b1; mode = 2'b00; en = 1'b1; a = 3'd0;
    reset1 = 1'b1; mode1 = 2'b00; en1 = 1'b1; a1 = 1'b0;

    vecs[0]  = '{1'b1, 2'b00, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 3'd5, 8'h20, 3'd5, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 3'd7, 8'h80, 3'd7, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 3'd2, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 3'd2, 8'h04, 3'd2, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 3'd6, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 3'd6, 8'h04, 3'd2, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 2'b10, 1'b1, 3'd6, 8'h00, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].md, vecs[i].e, vecs[i].sel);
      chk($sformatf("vec%0d", i), cur(),
          pack(vecs[i].ey, vecs[i].eidx, vecs[i].ewrap, vecs[i].evalid));
    end

    // Fresh scan from OFF: index steps every 4 cycles, single wrap at cycle 32.
    step(1'b0, 2'b00, 1'b1, 3'd0);
    for (int i = 0; i < 36; i++) begin
      step(1'b0, 2'b10, 1'b1, 3'd0);
      ei = 3'((i / 4) % 8);
      chk($sformatf("scan%0d", i), cur(), pack(8'h01 << ei, ei, (i == 32), 1'b1));
    end

    // HOLD with prescaler at 2, then resume.
    step(1'b0, 2'b00, 1'b1, 3'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("pre_hold", cur(), pack(8'h08, 3'd3, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b11, 1'b1, 3'd0);
      chk($sformatf("hold%0d", i), cur(), pack(8'h08, 3'd3, 1'b0, 1'b1));
    end
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("resume1", cur(), pack(8'h08, 3'd3, 1'b0, 1'b1));
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("resume2", cur(), pack(8'h10, 3'd4, 1'b0, 1'b1));

    // Enable gap at idx 6 with prescaler at 0.
    for (int i = 0; i < 8; i++) step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("at6", cur(), pack(8'h40, 3'd6, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b10, 1'b0, 3'd0);
      chk($sformatf("gap%0d", i), cur(), pack(8'h00, 3'd6, 1'b0, 1'b0));
    end
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("en_back", cur(), pack(8'h40, 3'd6, 1'b0, 1'b1));
    step(1'b0, 2'b10, 1'b1, 3'd0);
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("gap_no_adv", cur(), pack(8'h40, 3'd6, 1'b0, 1'b1));
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("after_gap", cur(), pack(8'h80, 3'd7, 1'b0, 1'b1));

    // Reset mid-scan at idx 7, mode stays SCAN.
    step(1'b0, 2'b10, 1'b1, 3'd0);
    step(1'b1, 2'b10, 1'b1, 3'd0);
    chk("mid_reset", cur(), pack(8'h00, 3'd0, 1'b0, 1'b0));
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("post_reset", cur(), pack(8'h01, 3'd0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("post_reset_hold", cur(), pack(8'h01, 3'd0, 1'b0, 1'b1));
    step(1'b0, 2'b10, 1'b1, 3'd0);
    chk("post_reset_adv", cur(), pack(8'h02, 3'd1, 1'b0, 1'b1));

    // N=1, DIV=1 instance: toggles every cycle, wrap every second cycle.
    @(posedge clk); #1;
    chk("n1_reset", {12'h000, y1, idx1, wrap1, valid1}, 16'h0000);
    reset1 = 1'b0;
    mode1  = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("n1_scan%0d", k), {12'h000, y1, idx1, wrap1, valid1},
          {12'h000, ((k % 2) == 1) ? 2'b10 : 2'b01, 1'((k % 2) == 1),
           (k > 0) && ((k % 2) == 0), 1'b1});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
